// File: rtl/ucie_ctl_sb_pkg.sv
// Shared defaults, word type and credit-width helper for the sideband config receive path.
`default_nettype none

package ucie_ctl_sb_pkg;

   localparam int DEF_NC       = 32;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_INIT_CRD = 4;
   localparam int DEF_MAX_CRD  = 8;

   typedef logic [DEF_NC-1:0] sb_word_t;

   function automatic int crd_width(input int max_crd);
      return $clog2(max_crd + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ucie_ctl_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a synchronous flush; caller must not push when full without a pop.
`default_nettype none

module ucie_ctl_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is not reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

endmodule

`default_nettype wire

// File: rtl/ucie_ctl_sb_cfg_rx.sv
// Sideband config receive path: buffers partner words and delivers them to the RDI under adapter credits.
// Optional macro UCIE_CTL_SB_RX_OVF_CNT_EN adds an 8-bit saturating dropped-word counter (o_ovf_count).
`default_nettype none

module ucie_ctl_sb_cfg_rx
   import ucie_ctl_sb_pkg::*;
#(
   parameter int NC       = DEF_NC,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int INIT_CRD = DEF_INIT_CRD,
   parameter int MAX_CRD  = DEF_MAX_CRD,
   localparam int LW      = $clog2(DEPTH + 1),
   localparam int CW      = crd_width(MAX_CRD)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_sb_data_valid,
   input  logic [NC-1:0] i_data_received_sb,
   input  logic          i_rdi_lp_cfg_crd,
   input  logic          i_flush,
   output logic [NC-1:0] o_rdi_pl_cfg,
   output logic          o_rdi_pl_cfg_vld,
   output logic [LW-1:0] o_fifo_level,
   output logic [CW-1:0] o_credit_count,
   output logic          o_overflow,
   output logic          o_crd_overflow
`ifdef UCIE_CTL_SB_RX_OVF_CNT_EN
   ,
   output logic [7:0]    o_ovf_count
`endif
);

   logic [CW-1:0] credit;
   logic [NC-1:0] head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          push;
   logic          drop;
   logic          crd_ret;
   logic          crd_sat;

   // Flush masks every event so a flush cycle behaves exactly like reset.
   assign pop     = !i_flush && !fifo_empty && (credit != '0);
   assign push    = !i_flush && i_sb_data_valid && (!fifo_full || pop);
   assign drop    = !i_flush && i_sb_data_valid && fifo_full && !pop;
   assign crd_ret = !i_flush && i_rdi_lp_cfg_crd;
   assign crd_sat = crd_ret && !pop && (credit == CW'(MAX_CRD));

   ucie_ctl_sync_fifo #(
      .WIDTH (NC),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .flush (i_flush),
      .push  (push),
      .wdata (i_data_received_sb),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (o_fifo_level)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         o_rdi_pl_cfg     <= '0;
         o_rdi_pl_cfg_vld <= 1'b0;
         credit           <= CW'(INIT_CRD);
         o_overflow       <= 1'b0;
         o_crd_overflow   <= 1'b0;
      end else begin
         o_rdi_pl_cfg_vld <= pop;
         if (pop) o_rdi_pl_cfg <= head;
         // Return and consume together cancel; a saturated return is dropped.
         if (crd_ret && !pop && !crd_sat) credit <= credit + 1'b1;
         else if (pop && !crd_ret)        credit <= credit - 1'b1;
         if (drop)    o_overflow     <= 1'b1;
         if (crd_sat) o_crd_overflow <= 1'b1;
      end
   end

   assign o_credit_count = credit;

`ifdef UCIE_CTL_SB_RX_OVF_CNT_EN
   logic [7:0] ovf_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush)            ovf_cnt <= '0;
      else if (drop && ovf_cnt != 8'hFF)  ovf_cnt <= ovf_cnt + 1'b1;
   end

   assign o_ovf_count = ovf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ucie_ctl_sb_cfg_rx.sv
// Randomised self-checking bench for ucie_ctl_sb_cfg_rx against a queue-based reference model.
`default_nettype none

module tb_ucie_ctl_sb_cfg_rx;
   import ucie_ctl_sb_pkg::*;

   localparam int DEPTH    = DEF_DEPTH;
   localparam int INIT_CRD = DEF_INIT_CRD;
   localparam int MAX_CRD  = DEF_MAX_CRD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sb_valid;
   sb_word_t    sb_data;
   logic        crd;
   logic        flush;
   sb_word_t    cfg;
   logic        cfg_vld;
   logic [3:0]  level;
   logic [3:0]  credit;
   logic        ovf;
   logic        crd_ovf;
`ifdef UCIE_CTL_SB_RX_OVF_CNT_EN
   logic [7:0]  ovf_count;
`endif

   always #5 clk = ~clk;

   ucie_ctl_sb_cfg_rx dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_sb_data_valid    (sb_valid),
      .i_data_received_sb (sb_data),
      .i_rdi_lp_cfg_crd   (crd),
      .i_flush            (flush),
      .o_rdi_pl_cfg       (cfg),
      .o_rdi_pl_cfg_vld   (cfg_vld),
      .o_fifo_level       (level),
      .o_credit_count     (credit),
      .o_overflow         (ovf),
      .o_crd_overflow     (crd_ovf)
`ifdef UCIE_CTL_SB_RX_OVF_CNT_EN
      ,
      .o_ovf_count        (ovf_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   sb_word_t q[$];
   int       m_crd;
   bit       m_vld;
   sb_word_t m_cfg;
   bit       m_ovf;
   bit       m_covf;
   int       m_cnt;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_crd  = INIT_CRD;
      m_vld  = 0;
      m_cfg  = '0;
      m_ovf  = 0;
      m_covf = 0;
      m_cnt  = 0;
   endtask

   task automatic model_edge(input bit r_n, input bit v, input sb_word_t d, input bit c, input bit f);
      bit deliver;
      if (!r_n || f) begin
         model_clear();
         return;
      end
      deliver = (q.size() > 0) && (m_crd > 0);
      m_vld   = deliver;
      if (deliver) m_cfg = q.pop_front();
      if (v) begin
         if (q.size() < DEPTH) q.push_back(d);
         else begin
            m_ovf = 1;
            if (m_cnt < 255) m_cnt++;
         end
      end
      if (c && !deliver) begin
         if (m_crd == MAX_CRD) m_covf = 1;
         else m_crd++;
      end else if (!c && deliver) begin
         m_crd--;
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, compare shortly after.
   task automatic step(input bit r_n, input bit v, input sb_word_t d, input bit c, input bit f);
      rst_n    = r_n;
      sb_valid = v;
      sb_data  = d;
      crd      = c;
      flush    = f;
      @(posedge clk);
      model_edge(r_n, v, d, c, f);
      #1;
      check_eq("vld",     cfg_vld, m_vld);
      check_eq("cfg",     cfg,     m_cfg);
      check_eq("level",   level,   q.size());
      check_eq("credit",  credit,  m_crd);
      check_eq("ovf",     ovf,     m_ovf);
      check_eq("crd_ovf", crd_ovf, m_covf);
`ifdef UCIE_CTL_SB_RX_OVF_CNT_EN
      check_eq("ovf_count", ovf_count, m_cnt);
`endif
   endtask

   initial begin
      int vp, cp;
      model_clear();
      rst_n = 0; sb_valid = 0; sb_data = '0; crd = 0; flush = 0;

      step(0, 0, '0, 0, 0);
      step(0, 1, 32'hDEAD_BEEF, 1, 0);
      check_eq("rst_credit", credit, INIT_CRD);
      check_eq("rst_level", level, 0);

      // Three consecutive words with four credits
      step(1, 1, 32'hA5A5_0001, 0, 0);
      check_eq("lat_no_vld", cfg_vld, 0);
      step(1, 1, 32'hA5A5_0002, 0, 0);
      check_eq("first_word", cfg, 32'hA5A5_0001);
      step(1, 1, 32'hA5A5_0003, 0, 0);
      step(1, 0, '0, 0, 0);
      check_eq("third_word", cfg, 32'hA5A5_0003);
      check_eq("credit_left", credit, 1);

      // Credit runs out, FIFO fills, overflow
      for (int i = 0; i < 10; i++) step(1, 1, 32'h1000_0000 + i, 0, 0);
      check_eq("full_level", level, DEPTH);
      check_eq("full_ovf", ovf, 1);
      step(1, 0, '0, 1, 0);
      step(1, 1, 32'h2000_0000, 0, 0);
      check_eq("pop_push_level", level, DEPTH);

      // Credit saturation
      step(1, 0, '0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 0, '0, 1, 0);
      check_eq("sat_credit", credit, MAX_CRD);
      check_eq("sat_flag", crd_ovf, 1);
      step(1, 0, '0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 0, '0, 1, 0);
      step(1, 1, 32'h3000_0000, 0, 0);
      step(1, 0, '0, 1, 0);
      check_eq("crd_with_pop", credit, MAX_CRD);
      check_eq("crd_with_pop_flag", crd_ovf, 0);

      // Drain credits, buffer five, then flush alongside a write and a credit
      for (int i = 0; i < 8; i++) step(1, 1, 32'h4000_0000 + i, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 32'h5000_0000 + i, 0, 0);
      step(1, 1, 32'h6666_6666, 1, 1);
      check_eq("flush_level", level, 0);
      check_eq("flush_credit", credit, INIT_CRD);
      check_eq("flush_vld", cfg_vld, 0);
      for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0);

      // Randomised traffic in three bias modes
      for (int seg = 0; seg < 12; seg++) begin
         case (seg % 3)
            0:       begin vp = 50; cp = 50; end
            1:       begin vp = 90; cp = 10; end
            default: begin vp = 10; cp = 80; end
         endcase
         for (int i = 0; i < 150; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 99) < vp),
                 $urandom(),
                 ($urandom_range(0, 99) < cp),
                 ($urandom_range(0, 99) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
